// File: rtl/jt51_kon_ctrl_if.sv
// +--------------------------------------------------------------------------+
// | jt51_kon_ctrl_if : register-file side of the key-on scheduler            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

interface jt51_kon_ctrl_if;
    logic       kon_we;
    logic [7:0] kon_din;
    logic       kon_ready;
    logic       kon_pending;
    logic       kon_ovf;

    modport master (
        output kon_we,
        output kon_din,
        input  kon_ready,
        input  kon_pending,
        input  kon_ovf
    );

    modport slave (
        input  kon_we,
        input  kon_din,
        output kon_ready,
        output kon_pending,
        output kon_ovf
    );
endinterface

`default_nettype wire

// File: rtl/jt51_kon_ctrl.sv
// +--------------------------------------------------------------------------+
// | jt51_kon_ctrl : key-on scheduler, one key event committed per frame,     |
// |                 CSM forcing, serial per-slot keyon_II stream             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module jt51_kon_ctrl #(
    parameter int AW = 2
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        zero,
    jt51_kon_ctrl_if.slave   kon,
    input  wire logic        csm_trig,
    output logic             keyon_II,
    output logic [4:0]       slot
);

    localparam int          DEPTH = 2**AW;
    localparam logic [AW:0] FULL  = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        CSM_IDLE      = 2'd0,
        CSM_ARMED     = 2'd1,
        CSM_FORCE_ON  = 2'd2,
        CSM_FORCE_OFF = 2'd3
    } csm_state_t;

    // Entry layout: {ch[2:0], C2, M2, C1, M1}
    logic [6:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          push;
    logic          pop;
    logic          pending;
    logic          ovf;

    logic [31:0]   kon_state;
    logic [31:0]   kon_next;
    logic [31:0]   eff_next;
    logic [6:0]    head;
    logic [2:0]    head_ch;
    logic [3:0]    head_mask;

    csm_state_t    csm_state;
    csm_state_t    csm_next;
    logic          rearm;
    logic          rearm_next;

    logic [4:0]    slot_next;
    logic          unused_din7;

    assign unused_din7     = kon.kon_din[7];
    assign kon.kon_ready   = (count != FULL);
    assign kon.kon_pending = pending;
    assign kon.kon_ovf     = ovf;

    // Ready is judged on the pre-pop fill level, so a full FIFO drops even in a pop cycle
    assign push = kon.kon_we && kon.kon_ready;
    assign pop  = zero && (count != '0);

    assign head      = mem[rd_ptr];
    assign head_ch   = head[6:4];
    assign head_mask = head[3:0];

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + (AW+1)'(1);
        end else if (pop && !push) begin
            count_next = count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {kon.kon_din[2:0], kon.kon_din[6:3]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            pending <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count   <= count_next;
            pending <= (count_next != '0);
            if (kon.kon_we && !kon.kon_ready) begin
                ovf <= 1'b1;
            end
        end
    end

    // Mask bits go M1->op0, M2->op1, C1->op2, C2->op3 (slot = op*8 + ch)
    always_comb begin
        kon_next = kon_state;
        if (pop) begin
            kon_next[{2'd0, head_ch}] = head_mask[0];
            kon_next[{2'd1, head_ch}] = head_mask[2];
            kon_next[{2'd2, head_ch}] = head_mask[1];
            kon_next[{2'd3, head_ch}] = head_mask[3];
        end
    end

    always_comb begin
        csm_next   = csm_state;
        rearm_next = rearm;
        unique case (csm_state)
            CSM_IDLE: begin
                if (csm_trig) begin
                    csm_next = CSM_ARMED;
                end
            end
            CSM_ARMED: begin
                if (zero) begin
                    csm_next = CSM_FORCE_ON;
                end
            end
            CSM_FORCE_ON: begin
                if (zero) begin
                    csm_next = CSM_FORCE_OFF;
                end
            end
            CSM_FORCE_OFF: begin
                if (zero) begin
                    csm_next   = rearm ? CSM_ARMED : CSM_IDLE;
                    rearm_next = 1'b0;
                end
            end
            default: csm_next = CSM_IDLE;
        endcase
        if (csm_trig && (csm_state != CSM_IDLE)) begin
            rearm_next = 1'b1;
        end
    end

    // Forcing tracks the post-edge CSM state so a forced frame starts exactly at slot 0
    always_comb begin
        eff_next = kon_next;
        if (csm_next == CSM_FORCE_ON) begin
            eff_next = '1;
        end else if (csm_next == CSM_FORCE_OFF) begin
            eff_next = '0;
        end
    end

    assign slot_next = zero ? 5'd0 : slot + 5'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kon_state <= '0;
            csm_state <= CSM_IDLE;
            rearm     <= 1'b0;
            slot      <= '0;
            keyon_II  <= 1'b0;
        end else begin
            kon_state <= kon_next;
            csm_state <= csm_next;
            rearm     <= rearm_next;
            slot      <= slot_next;
            keyon_II  <= eff_next[slot_next];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_jt51_kon_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_jt51_kon_ctrl : scoreboard bench for the key-on scheduler             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_jt51_kon_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       zero = 1'b0;
    logic       csm_trig = 1'b0;
    logic       keyon_II;
    logic [4:0] slot;

    jt51_kon_ctrl_if kif ();

    jt51_kon_ctrl #(.AW(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .zero     (zero),
        .kon      (kif),
        .csm_trig (csm_trig),
        .keyon_II (keyon_II),
        .slot     (slot)
    );

    always #5 clk = ~clk;

    typedef struct {
        int slot;
        bit key;
        bit rdy;
        bit pend;
        bit ovf;
    } exp_t;

    exp_t sb[$];

    // Frame-level reference: key bitmap, FIFO of raw writes, CSM phase number
    bit [31:0] ks;
    bit [7:0]  mq[$];
    int        phase;  // 0 idle, 1 armed, 2 forced on, 3 forced off
    bit        rearm;
    int        mslot;
    bit        movf;
    int        fcnt;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ks = '0;
        mq.delete();
        phase = 0;
        rearm = 1'b0;
        mslot = 0;
        movf  = 1'b0;
    endtask

    task automatic model_step(input bit z, input bit we, input bit [7:0] din, input bit trig);
        bit    room;
        bit    old_re;
        int    old_phase;
        int    ch;
        bit [7:0] d;
        exp_t  e;
        room = (mq.size() < 4);
        if (z && mq.size() > 0) begin
            d  = mq.pop_front();
            ch = int'(d[2:0]);
            ks[ch]      = d[3];
            ks[ch + 8]  = d[5];
            ks[ch + 16] = d[4];
            ks[ch + 24] = d[6];
        end
        if (we) begin
            if (room) mq.push_back(din);
            else      movf = 1'b1;
        end
        old_re    = rearm;
        old_phase = phase;
        if (phase == 3 && z) rearm = 1'b0;
        if (trig && old_phase != 0) rearm = 1'b1;
        case (old_phase)
            0: if (trig) phase = 1;
            1: if (z) phase = 2;
            2: if (z) phase = 3;
            default: if (z) phase = old_re ? 1 : 0;
        endcase
        mslot = z ? 0 : (mslot + 1) % 32;
        e.slot = mslot;
        e.key  = (phase == 2) ? 1'b1 : (phase == 3) ? 1'b0 : ks[mslot];
        e.rdy  = (mq.size() < 4);
        e.pend = (mq.size() > 0);
        e.ovf  = movf;
        sb.push_back(e);
    endtask

    task automatic cycle(input bit z, input bit we, input bit [7:0] din, input bit trig);
        zero        = z;
        kif.kon_we  = we;
        kif.kon_din = din;
        csm_trig    = trig;
        @(posedge clk);
        model_step(z, we, din, trig);
        #1;
        zero        = 1'b0;
        kif.kon_we  = 1'b0;
        csm_trig    = 1'b0;
    endtask

    task automatic tick(input bit we, input bit [7:0] din, input bit trig, input bit early);
        bit z;
        z = (fcnt == 31) || early;
        fcnt = z ? 0 : fcnt + 1;
        cycle(z, we, din, trig);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},   int'(kif.kon_ready),   1);
        check({tag, "_pending"}, int'(kif.kon_pending), 0);
        check({tag, "_ovf"},     int'(kif.kon_ovf),     0);
        check({tag, "_keyon"},   int'(keyon_II),        0);
        check({tag, "_slot"},    int'(slot),            0);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("slot",        int'(slot),            e.slot);
            check("keyon_II",    int'(keyon_II),        int'(e.key));
            check("kon_ready",   int'(kif.kon_ready),   int'(e.rdy));
            check("kon_pending", int'(kif.kon_pending), int'(e.pend));
            check("kon_ovf",     int'(kif.kon_ovf),     int'(e.ovf));
        end
    end

    initial begin
        int guard;
        kif.kon_we  = 1'b0;
        kif.kon_din = 8'h00;
        model_reset();
        fcnt = 5;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // ch3 all operators on, written mid-frame
        idle(5);
        tick(1'b1, 8'h7B, 1'b0, 1'b0);
        idle(40);

        // on then off in the same frame: two consecutive frames show both
        tick(1'b1, 8'h7B, 1'b0, 1'b0);
        tick(1'b1, 8'h03, 1'b0, 1'b0);
        idle(70);

        // five writes with no zero pulse in between: fifth is dropped
        guard = 0;
        while (fcnt != 1 && guard < 64) begin
            idle(1);
            guard++;
        end
        for (int i = 0; i < 5; i++) tick(1'b1, {1'b0, 4'($urandom), 3'(i)}, 1'b0, 1'b0);
        check("ovf_after_drop", int'(kif.kon_ovf), 1);
        idle(150);
        check("ovf_sticky", int'(kif.kon_ovf), 1);

        // bit7 of the write is ignored
        tick(1'b1, 8'hA8, 1'b0, 1'b0);
        idle(40);

        // CSM with ch3 keyed, plus a re-trigger during the forced-on frame
        tick(1'b1, 8'h7B, 1'b0, 1'b0);
        idle(40);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        guard = 0;
        while (phase != 2 && guard < 200) begin
            idle(1);
            guard++;
        end
        check("csm_reach_force_on", phase, 2);
        idle(7);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        idle(200);

        // async reset while entries are queued and CSM is forcing
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        guard = 0;
        while (phase != 2 && guard < 200) begin
            idle(1);
            guard++;
        end
        check("csm_reach_force_on_2", phase, 2);
        tick(1'b1, 8'h7B, 1'b0, 1'b0);
        tick(1'b1, 8'h7C, 1'b0, 1'b0);
        tick(1'b1, 8'h7D, 1'b0, 1'b0);
        idle(3);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        sb.delete();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        fcnt = 10;
        idle(80);

        // randomized traffic, occasional early zero pulses
        for (int i = 0; i < 2000; i++) begin
            tick(($urandom_range(0, 11) == 0), 8'($urandom),
                 ($urandom_range(0, 149) == 0), ($urandom_range(0, 99) == 0));
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
